// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry, stack-pointer reset
// value and packed-port slicing helpers used by the register file and its bypass.
package cpu_pkg;

   localparam int          CPU_DATA_W   = 32;
   localparam int          CPU_NREGS    = 16;
   localparam int          CPU_NWR      = 2;
   localparam int          CPU_NRD      = 2;
   localparam int          CPU_SP_IDX   = 13;
   localparam logic [31:0] CPU_SP_RESET = 32'h8000_0000;
   localparam int          CPU_INSTR_W  = 32;

   // Control half of the decode pipeline register.
   typedef struct packed {
      logic cond;
      logic ls;
      logic valid;
   } pipe_ctl_t;

   // Low bit of field `idx` in a packed multi-port bus of `width`-bit fields.
   function automatic int port_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port bypass: forwards same-cycle write data over the stored value,
// with the highest-numbered matching write port taking priority.
module regfile_bypass
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = 4,
   parameter int NWR    = CPU_NWR
) (
   input  logic [DATA_W-1:0]     rf_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*ADDR_W-1:0] wr_addr,
   input  logic [NWR*DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0]     byp_data
);

   always_comb begin
      byp_data = rf_data;
      // Ascending scan so a later (higher) port overrides an earlier match.
      for (int k = 0; k < NWR; k++) begin
         if (wr_en[k] && (wr_addr[port_lo(k, ADDR_W) +: ADDR_W] == rd_addr)) begin
            byp_data = wr_data[port_lo(k, DATA_W) +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with write-to-read bypass, registered read ports
// and the decode pipeline register (instruction, condition, load/store, valid).
module regfile_mp
   import cpu_pkg::*;
#(
   parameter int                DATA_W   = CPU_DATA_W,
   parameter int                NREGS    = CPU_NREGS,
   parameter int                NWR      = CPU_NWR,
   parameter int                NRD      = CPU_NRD,
   parameter int                SP_IDX   = CPU_SP_IDX,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(CPU_SP_RESET),
   parameter int                INSTR_W  = CPU_INSTR_W,
   localparam int               ADDR_W   = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*ADDR_W-1:0] wr_addr,
   input  logic [NWR*DATA_W-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   input  logic [INSTR_W-1:0]    instr_in,
   input  logic                  cond_in,
   input  logic                  ls_in,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD*ADDR_W-1:0] rd_addr_q,
   output logic [INSTR_W-1:0]    instr_out,
   output logic                  cond_out,
   output logic                  ls_out,
   output logic                  valid_out
);

   logic [DATA_W-1:0]     regs_q [NREGS];
   logic [DATA_W-1:0]     regs_d [NREGS];
   logic [NRD*DATA_W-1:0] byp_data;
   logic [NRD*DATA_W-1:0] rd_data_q, rd_data_d;
   logic [NRD*ADDR_W-1:0] raddr_q, raddr_d;
   logic [INSTR_W-1:0]    instr_q, instr_d;
   pipe_ctl_t             ctl_q, ctl_d;

   // Power-on contents: identity values, with the stack pointer and the top
   // register overridden.
   function automatic logic [DATA_W-1:0] reset_val(input int idx);
      if (idx == SP_IDX)    return SP_RESET;
      if (idx == NREGS - 1) return '0;
      return DATA_W'(idx);
   endfunction

   // Write decode: later ports overwrite earlier ones on an address collision.
   always_comb begin
      regs_d = regs_q;
      for (int k = 0; k < NWR; k++) begin
         if (wr_en[k]) begin
            regs_d[wr_addr[port_lo(k, ADDR_W) +: ADDR_W]] = wr_data[port_lo(k, DATA_W) +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= reset_val(i);
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Stage boundary: register array read + bypass -> registered read ports
   for (genvar j = 0; j < NRD; j++) begin : g_rd
      regfile_bypass #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NWR    (NWR)
      ) u_bypass (
         .rf_data  (regs_q[rd_addr[port_lo(j, ADDR_W) +: ADDR_W]]),
         .rd_addr  (rd_addr[port_lo(j, ADDR_W) +: ADDR_W]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .byp_data (byp_data[port_lo(j, DATA_W) +: DATA_W])
      );
   end

   always_comb begin
      rd_data_d = rd_data_q;
      raddr_d   = raddr_q;
      if (rd_en && !stall) begin
         rd_data_d = byp_data;
         raddr_d   = rd_addr;
      end
   end

   // Stage boundary: decode pipeline register
   always_comb begin
      instr_d     = instr_q;
      ctl_d       = ctl_q;
      ctl_d.valid = 1'b0;
      if (!stall && cond_in) begin
         instr_d     = instr_in;
         ctl_d.cond  = cond_in;
         ctl_d.ls    = ls_in;
         ctl_d.valid = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q <= '0;
         raddr_q   <= '0;
         instr_q   <= '0;
         ctl_q     <= '0;
      end else begin
         rd_data_q <= rd_data_d;
         raddr_q   <= raddr_d;
         instr_q   <= instr_d;
         ctl_q     <= ctl_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_addr_q = raddr_q;
   assign instr_out = instr_q;
   assign cond_out  = ctl_q.cond;
   assign ls_out    = ctl_q.ls;
   assign valid_out = ctl_q.valid;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp at default parameters (32-bit, 16 regs, 2W/2R).
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  wr_en;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [31:0] instr_in;
   logic        cond_in;
   logic        ls_in;
   logic [63:0] rd_data;
   logic [7:0]  rd_addr_q;
   logic [31:0] instr_out;
   logic        cond_out;
   logic        ls_out;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   regfile_mp dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .instr_in  (instr_in),
      .cond_in   (cond_in),
      .ls_in     (ls_in),
      .rd_data   (rd_data),
      .rd_addr_q (rd_addr_q),
      .instr_out (instr_out),
      .cond_out  (cond_out),
      .ls_out    (ls_out),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] rd;
      logic [7:0]  ra;
      logic [31:0] ins;
      logic        cnd;
      logic        ls;
      logic        vld;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   logic [31:0] m [16];

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i] = i;
      m[13] = 32'h8000_0000;
      m[15] = 32'h0;
      cur   = '0;
      sb.delete();
   endtask

   // Drives one cycle of stimulus and pushes the expected post-edge outputs.
   task automatic step(input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic re, input logic [3:0] ra0, input logic [3:0] ra1,
                       input logic st, input logic [31:0] ins, input logic cnd, input logic lsf);
      exp_t        nx;
      logic [3:0]  a;
      logic [31:0] v;
      nx     = cur;
      nx.vld = 1'b0;
      if (re && !st) begin
         for (int j = 0; j < 2; j++) begin
            a = (j == 0) ? ra0 : ra1;
            v = m[a];
            if (we[0] && wa0 == a) v = wd0;
            if (we[1] && wa1 == a) v = wd1;
            nx.rd[j*32 +: 32] = v;
            nx.ra[j*4 +: 4]   = a;
         end
      end
      if (!st && cnd) begin
         nx.ins = ins;
         nx.cnd = 1'b1;
         nx.ls  = lsf;
         nx.vld = 1'b1;
      end
      if (we[0]) m[wa0] = wd0;
      if (we[1]) m[wa1] = wd1;
      cur = nx;
      sb.push_back(nx);
      wr_en    = we;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      rd_en    = re;
      rd_addr  = {ra1, ra0};
      stall    = st;
      instr_in = ins;
      cond_in  = cnd;
      ls_in    = lsf;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b0; stall = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0; instr_in = '0; cond_in = 1'b0; ls_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_addr_q !== 8'h0) begin
         errors++; $display("FAIL reset_rd: rd_data=%h rd_addr_q=%h want 0", rd_data, rd_addr_q);
      end
      checks++;
      if (instr_out !== 32'h0 || cond_out !== 1'b0 || ls_out !== 1'b0 || valid_out !== 1'b0) begin
         errors++; $display("FAIL reset_pipe: instr=%h c=%b l=%b v=%b want 0", instr_out, cond_out, ls_out, valid_out);
      end
      reset = 1'b1;
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd13, 4'd5, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd || rd_data !== {32'd5, 32'h8000_0000}) begin
         errors++; $display("FAIL reset_read: rd_data=%h want %h", rd_data, e.rd);
      end
      checks++;
      if (rd_addr_q !== e.ra) begin
         errors++; $display("FAIL reset_raddr: rd_addr_q=%h want %h", rd_addr_q, e.ra);
      end
   endtask

   task automatic test_collision();
      exp_t e;
      step(2'b11, 4'd3, 4'd3, 32'hAAAA, 32'hBBBB, 1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd) begin
         errors++; $display("FAIL collision_hold: rd_data=%h want %h", rd_data, e.rd);
      end
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd3, 4'd1, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd || rd_data[31:0] !== 32'hBBBB) begin
         errors++; $display("FAIL collision_read: rd_data=%h want %h", rd_data, e.rd);
      end
   endtask

   task automatic test_bypass();
      exp_t e;
      step(2'b01, 4'd7, 4'd0, 32'h1234, 32'h0, 1'b1, 4'd7, 4'd4, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd || rd_data[31:0] !== 32'h1234) begin
         errors++; $display("FAIL bypass_p0: rd_data=%h want %h", rd_data, e.rd);
      end
      step(2'b11, 4'd9, 4'd9, 32'h1111, 32'h2222, 1'b1, 4'd9, 4'd9, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd) begin
         errors++; $display("FAIL bypass_prio: rd_data=%h want %h", rd_data, e.rd);
      end
      step(2'b10, 4'd0, 4'd6, 32'h0, 32'h6666, 1'b1, 4'd7, 4'd6, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd || rd_addr_q !== e.ra) begin
         errors++; $display("FAIL bypass_p1: rd_data=%h ra=%h want %h %h", rd_data, rd_addr_q, e.rd, e.ra);
      end
   endtask

   task automatic test_stall();
      exp_t e;
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 32'hCAFE_0001, 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if (instr_out !== e.ins || valid_out !== 1'b1 || ls_out !== 1'b1) begin
         errors++; $display("FAIL stall_pre: instr=%h v=%b want %h 1", instr_out, valid_out, e.ins);
      end
      step(2'b01, 4'd2, 4'd0, 32'h55, 32'h0, 1'b1, 4'd2, 4'd2, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd || rd_addr_q !== e.ra || instr_out !== e.ins || ls_out !== e.ls || valid_out !== 1'b0) begin
         errors++; $display("FAIL stall_hold: rd=%h instr=%h v=%b want %h %h 0", rd_data, instr_out, valid_out, e.rd, e.ins);
      end
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd2, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd || rd_data[31:0] !== 32'h55) begin
         errors++; $display("FAIL stall_write: rd_data=%h want %h", rd_data, e.rd);
      end
   endtask

   task automatic test_cond();
      exp_t e;
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 32'h1111_1111, 1'b1, 1'b0);
      e = sb.pop_front();
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 32'h2222_2222, 1'b0, 1'b1);
      e = sb.pop_front();
      checks++;
      if (instr_out !== e.ins || instr_out !== 32'h1111_1111 || valid_out !== 1'b0 || ls_out !== e.ls) begin
         errors++; $display("FAIL cond_off: instr=%h v=%b want %h 0", instr_out, valid_out, e.ins);
      end
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 32'hE3A0_1001, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (instr_out !== 32'hE3A0_1001 || valid_out !== 1'b1 || cond_out !== 1'b1) begin
         errors++; $display("FAIL cond_on: instr=%h v=%b c=%b want e3a01001 1 1", instr_out, valid_out, cond_out);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int n = 0; n < 60; n++) begin
         step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 4) == 0), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         e = sb.pop_front();
         checks++;
         if ({rd_data, rd_addr_q, instr_out, cond_out, ls_out, valid_out} !== e) begin
            errors++;
            $display("FAIL b2b[%0d]: rd=%h ra=%h ins=%h c%b l%b v%b want rd=%h ra=%h ins=%h c%b l%b v%b",
                     n, rd_data, rd_addr_q, instr_out, cond_out, ls_out, valid_out,
                     e.rd, e.ra, e.ins, e.cnd, e.ls, e.vld);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      step(2'b11, 4'd2, 4'd7, 32'h0BAD_0002, 32'h0BAD_0007, 1'b1, 4'd1, 4'd2, 1'b0, 32'h7777_7777, 1'b1, 1'b1);
      e = sb.pop_front();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_addr_q !== 8'h0 || instr_out !== 32'h0 ||
          cond_out !== 1'b0 || ls_out !== 1'b0 || valid_out !== 1'b0) begin
         errors++; $display("FAIL async_reset: rd=%h ra=%h ins=%h c%b l%b v%b want 0",
                            rd_data, rd_addr_q, instr_out, cond_out, ls_out, valid_out);
      end
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd13, 4'd15, 1'b1, 32'h9999_9999, 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if (rd_data !== 64'h0 || instr_out !== 32'h0 || valid_out !== 1'b0 || rd_data !== e.rd) begin
         errors++; $display("FAIL reset_stall: rd=%h ins=%h v=%b want 0", rd_data, instr_out, valid_out);
      end
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd2, 4'd7, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd || rd_data !== {32'd7, 32'd2}) begin
         errors++; $display("FAIL restore_2_7: rd_data=%h want %h", rd_data, e.rd);
      end
      step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd13, 4'd15, 1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.rd || rd_data !== {32'h0, 32'h8000_0000}) begin
         errors++; $display("FAIL restore_sp: rd_data=%h want %h", rd_data, e.rd);
      end
   endtask

   initial begin
      test_reset();
      test_collision();
      test_bypass();
      test_stall();
      test_cond();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
